xgmii_rx_frame_fifo: RTL and testbench



---
 rtl/xgmii_rx_frame_fifo.sv | 194 +++++++++++++++++++
 tb/tb_xgmii_rx_frame_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_rx_frame_fifo.sv
// Store-and-forward XGMII receive frame buffer: keeps only complete frames and
// replays each committed frame contiguously with at least one idle word between frames.
module xgmii_rx_frame_fifo #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned MAX_WORDS  = 1200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_xgmii_ctrl,
  input  logic [63:0]           in_xgmii_data,
  output logic [7:0]            out_xgmii_ctrl,
  output logic [63:0]           out_xgmii_data,
  output logic [31:0]           frames_committed,
  output logic [31:0]           frames_dropped,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CntW  = $clog2(MAX_WORDS + 1);

  typedef logic [DEPTH_LOG2:0] ptr_t;
  localparam ptr_t        FullLevel = ptr_t'(Depth);
  localparam logic [71:0] IdleWord  = {8'hFF, 64'h0707070707070707};

  typedef enum logic [1:0] {WrIdle, WrStore, WrDiscard} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdSend, RdGap} rd_state_e;

  function automatic logic has_term(input logic [7:0] c, input logic [63:0] d);
    logic t;
    t = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c[i] && (d[8*i +: 8] == 8'hFD)) t = 1'b1;
    end
    return t;
  endfunction

  wr_state_e         wr_state_q, wr_state_d;
  rd_state_e         rd_state_q, rd_state_d;
  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              frame_start_q, frame_start_d;
  ptr_t              commit_ptr_q, commit_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   word_cnt_q, word_cnt_d;
  logic [31:0]       committed_q, committed_d;
  logic [31:0]       dropped_q, dropped_d;
  logic              mem_vld_q, mem_vld_d;
  logic [71:0]       out_q, out_d;
  logic [71:0]       mem_rd_q;
  logic [71:0]       mem [Depth];

  logic  in_start, in_term, full, begin_frame, wr_en, rd_en, pending, send_term;
  ptr_t  base, wr_addr;

  assign in_start = in_xgmii_ctrl[0] && (in_xgmii_data[7:0] == 8'hFB);
  assign in_term  = has_term(in_xgmii_ctrl, in_xgmii_data);
  // Full uses the pre-read pointer, so a same-cycle read never helps a write.
  assign full     = (wr_ptr_q - rd_ptr_q) == FullLevel;

  always_comb begin
    wr_state_d    = wr_state_q;
    wr_ptr_d      = wr_ptr_q;
    frame_start_d = frame_start_q;
    commit_ptr_d  = commit_ptr_q;
    word_cnt_d    = word_cnt_q;
    committed_d   = committed_q;
    dropped_d     = dropped_q;
    wr_en         = 1'b0;
    wr_addr       = wr_ptr_q;
    begin_frame   = 1'b0;
    base          = wr_ptr_q;
    unique case (wr_state_q)
      WrIdle: begin
        if (in_start) begin_frame = 1'b1;
      end
      WrStore: begin
        if (in_start) begin
          // Aborted by a new start: rewind and begin the new frame in place.
          dropped_d   = dropped_q + 32'd1;
          base        = frame_start_q;
          begin_frame = 1'b1;
        end else if (full || (word_cnt_q >= CntW'(MAX_WORDS))) begin
          wr_ptr_d   = frame_start_q;
          dropped_d  = dropped_q + 32'd1;
          wr_state_d = in_term ? WrIdle : WrDiscard;
        end else begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          if (in_term) begin
            commit_ptr_d = wr_ptr_q + 1'b1;
            committed_d  = committed_q + 32'd1;
            wr_state_d   = WrIdle;
          end
        end
      end
      WrDiscard: begin
        if (in_start) begin_frame = 1'b1;
        else if (in_term) wr_state_d = WrIdle;
      end
      default: wr_state_d = WrIdle;
    endcase
    if (begin_frame) begin
      if ((base - rd_ptr_q) == FullLevel) begin
        wr_ptr_d   = base;
        dropped_d  = dropped_d + 32'd1;
        wr_state_d = in_term ? WrIdle : WrDiscard;
      end else begin
        wr_en         = 1'b1;
        wr_addr       = base;
        frame_start_d = base;
        wr_ptr_d      = base + 1'b1;
        word_cnt_d    = CntW'(1);
        if (in_term) begin
          commit_ptr_d = base + 1'b1;
          committed_d  = committed_d + 32'd1;
          wr_state_d   = WrIdle;
        end else begin
          wr_state_d = WrStore;
        end
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_ptr_d   = rd_ptr_q;
    rd_en      = 1'b0;
    out_d      = IdleWord;
    pending    = rd_ptr_q != commit_ptr_q;
    send_term  = mem_vld_q && has_term(mem_rd_q[71:64], mem_rd_q[63:0]);
    unique case (rd_state_q)
      RdIdle: begin
        if (pending) rd_state_d = RdSend;
      end
      RdSend: begin
        if (mem_vld_q) out_d = mem_rd_q;
        if (send_term) rd_state_d = RdGap;
        else if (pending) rd_en = 1'b1;
      end
      RdGap: begin
        // Prefetch during the gap so the next frame follows exactly one idle.
        if (pending) begin
          rd_en      = 1'b1;
          rd_state_d = RdSend;
        end else begin
          rd_state_d = RdIdle;
        end
      end
      default: rd_state_d = RdIdle;
    endcase
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    mem_vld_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[DEPTH_LOG2-1:0]] <= {in_xgmii_ctrl, in_xgmii_data};
    if (rd_en) mem_rd_q <= mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_state_q    <= WrIdle;
      rd_state_q    <= RdIdle;
      wr_ptr_q      <= '0;
      frame_start_q <= '0;
      commit_ptr_q  <= '0;
      rd_ptr_q      <= '0;
      word_cnt_q    <= '0;
      committed_q   <= '0;
      dropped_q     <= '0;
      mem_vld_q     <= 1'b0;
      out_q         <= IdleWord;
    end else begin
      wr_state_q    <= wr_state_d;
      rd_state_q    <= rd_state_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_start_q <= frame_start_d;
      commit_ptr_q  <= commit_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      word_cnt_q    <= word_cnt_d;
      committed_q   <= committed_d;
      dropped_q     <= dropped_d;
      mem_vld_q     <= mem_vld_d;
      out_q         <= out_d;
    end
  end

  assign out_xgmii_ctrl   = out_q[71:64];
  assign out_xgmii_data   = out_q[63:0];
  assign frames_committed = committed_q;
  assign frames_dropped   = dropped_q;
  assign fifo_level       = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_xgmii_rx_frame_fifo.sv
// Bench for xgmii_rx_frame_fifo: two small instances (length-limited and depth-limited)
// fed identical traffic; replayed words are checked against a per-instance scoreboard.
module tb_xgmii_rx_frame_fifo;

  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ic = 8'hFF;
  logic [63:0] id = 64'h0707070707070707;
  logic [7:0]  oc  [2];
  logic [63:0] od  [2];
  logic [31:0] fc  [2];
  logic [31:0] fd  [2];
  logic [4:0]  lvl [2];

  always #5 clk = ~clk;

  xgmii_rx_frame_fifo #(.DEPTH_LOG2(4), .MAX_WORDS(12)) dut_a (
    .clk(clk), .reset(reset), .in_xgmii_ctrl(ic), .in_xgmii_data(id),
    .out_xgmii_ctrl(oc[0]), .out_xgmii_data(od[0]),
    .frames_committed(fc[0]), .frames_dropped(fd[0]), .fifo_level(lvl[0])
  );

  xgmii_rx_frame_fifo #(.DEPTH_LOG2(4), .MAX_WORDS(32)) dut_b (
    .clk(clk), .reset(reset), .in_xgmii_ctrl(ic), .in_xgmii_data(id),
    .out_xgmii_ctrl(oc[1]), .out_xgmii_data(od[1]),
    .frames_committed(fc[1]), .frames_dropped(fd[1]), .fifo_level(lvl[1])
  );

  int          errors = 0;
  int          checks = 0;
  logic [71:0] sbq [2][$];
  bit          in_frame [2];
  int          idle_run [2];
  int          last_gap [2];

  typedef struct {
    int len; int lane; bit frag; int gap; bit ok_a; bit ok_b; int pre_gap;
    int ca; int da; int cb; int db;
  } vec_t;
  vec_t tbl [10];

  function automatic bit w_term(input logic [71:0] w);
    bit t;
    t = 1'b0;
    for (int i = 0; i < 8; i++) if (w[64+i] && (w[8*i +: 8] == 8'hFD)) t = 1'b1;
    return t;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] c, input logic [63:0] d);
    @(posedge clk);
    #1;
    ic = c;
    id = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(8'hFF, 64'h0707070707070707);
  endtask

  // Builds a frame (start, data with one FE error char, terminate in 'lane'); a fragment
  // has no terminate. Words expected to be replayed are queued per instance.
  task automatic send_frame(input int len, input int lane, input bit frag, input bit ok_a,
                            input bit ok_b, output logic [71:0] first);
    logic [7:0]  c;
    logic [63:0] d;
    logic [31:0] r;
    logic [31:0] r2;
    first = '0;
    for (int i = 0; i < len; i++) begin
      r  = $urandom;
      r2 = $urandom;
      c  = 8'h00;
      d  = {r, r2};
      if (i == 0) begin
        c = 8'h01;
        d[7:0] = 8'hFB;
        first = {c, d};
      end else if (!frag && i == len - 1) begin
        for (int b = 0; b < 8; b++) begin
          if (b == lane) begin
            c[b] = 1'b1;
            d[8*b +: 8] = 8'hFD;
          end else if (b > lane) begin
            c[b] = 1'b1;
            d[8*b +: 8] = 8'h07;
          end
        end
      end else if (i == 2) begin
        c = 8'h04;
        d[23:16] = 8'hFE;
      end
      if (ok_a) sbq[0].push_back({c, d});
      if (ok_b) sbq[1].push_back({c, d});
      drive(c, d);
    end
  endtask

  // Output monitor: every non-idle word must match the scoreboard, frames contiguous,
  // at least one idle between frames.
  initial begin
    logic [71:0] w;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (reset) begin
          in_frame[k] = 1'b0;
          idle_run[k] = 0;
        end else begin
          w = {oc[k], od[k]};
          if (w == IDLE_W) begin
            if (in_frame[k]) begin
              errors++;
              checks++;
              $display("FAIL frame_contig[%0d]: got idle want frame data", k);
            end
            idle_run[k]++;
          end else begin
            if (!in_frame[k]) begin
              last_gap[k] = idle_run[k];
              chk($sformatf("inter_frame_idle_zero[%0d]", k), 72'(idle_run[k] == 0), 72'd0);
              in_frame[k] = 1'b1;
            end
            if (sbq[k].size() == 0) begin
              errors++;
              checks++;
              $display("FAIL unexpected_word[%0d]: got %0h want idle", k, w);
            end else begin
              chk($sformatf("replay[%0d]", k), w, sbq[k].pop_front());
            end
            if (w_term(w)) in_frame[k] = 1'b0;
            idle_run[k] = 0;
          end
        end
      end
    end
  end

  initial begin
    logic [71:0] first;
    //          len lane frag gap a b pre  ca da cb db
    tbl[0] = '{ 4,  0,   0,   0, 1, 1, -1,  0, 0, 0, 0};
    tbl[1] = '{ 5,  7,   0,  20, 1, 1,  1,  3, 0, 3, 0};
    tbl[2] = '{ 4,  0,   1,   0, 0, 0, -1,  0, 0, 0, 0};
    tbl[3] = '{ 4,  1,   0,  20, 1, 1, -1,  4, 1, 4, 1};
    tbl[4] = '{14,  2,   0,  25, 0, 1, -1,  4, 2, 5, 1};
    tbl[5] = '{12,  4,   0,  20, 1, 1, -1,  5, 2, 6, 1};
    tbl[6] = '{17,  5,   0,  20, 0, 0, -1,  5, 3, 6, 2};
    tbl[7] = '{16,  6,   0,  30, 0, 1, -1,  5, 4, 7, 2};
    tbl[8] = '{20,  3,   0,   0, 0, 0, -1,  0, 0, 0, 0};
    tbl[9] = '{ 5,  3,   0,  20, 1, 1, -1,  6, 5, 8, 3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("reset_out[%0d]", k), {oc[k], od[k]}, IDLE_W);
      chk($sformatf("reset_committed[%0d]", k), 72'(fc[k]), 72'd0);
      chk($sformatf("reset_dropped[%0d]", k), 72'(fd[k]), 72'd0);
      chk($sformatf("reset_level[%0d]", k), 72'(lvl[k]), 72'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    idle(3);

    // 8-word frame, terminate in lane 3: level and exact replay latency.
    send_frame(8, 3, 1'b0, 1'b1, 1'b1, first);
    idle(1);
    @(negedge clk);
    chk("level_after_commit_a", 72'(lvl[0]), 72'd8);
    chk("level_after_commit_b", 72'(lvl[1]), 72'd8);
    for (int j = 1; j <= 3; j++) begin
      idle(1);
      @(negedge clk);
      chk($sformatf("latency_t+%0d", j), {oc[0], od[0]}, (j == 3) ? first : IDLE_W);
    end
    idle(20);
    @(negedge clk);
    chk("committed_first_a", 72'(fc[0]), 72'd1);
    chk("committed_first_b", 72'(fc[1]), 72'd1);

    for (int r = 0; r < 10; r++) begin
      send_frame(tbl[r].len, tbl[r].lane, tbl[r].frag, tbl[r].ok_a, tbl[r].ok_b, first);
      if (tbl[r].gap > 0) begin
        idle(tbl[r].gap);
        @(negedge clk);
        chk($sformatf("rec%0d committed_a", r), 72'(fc[0]), 72'(tbl[r].ca));
        chk($sformatf("rec%0d dropped_a", r), 72'(fd[0]), 72'(tbl[r].da));
        chk($sformatf("rec%0d committed_b", r), 72'(fc[1]), 72'(tbl[r].cb));
        chk($sformatf("rec%0d dropped_b", r), 72'(fd[1]), 72'(tbl[r].db));
        chk($sformatf("rec%0d level_a", r), 72'(lvl[0]), 72'd0);
        chk($sformatf("rec%0d level_b", r), 72'(lvl[1]), 72'd0);
        if (tbl[r].pre_gap >= 0)
          chk($sformatf("rec%0d idle_gap", r), 72'(last_gap[0]), 72'(tbl[r].pre_gap));
      end
    end

    // Reset in the middle of a frame after three stored words.
    send_frame(3, 0, 1'b1, 1'b0, 1'b0, first);
    @(posedge clk);
    #1;
    reset = 1'b1;
    ic = 8'hFF;
    id = 64'h0707070707070707;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midreset_out[%0d]", k), {oc[k], od[k]}, IDLE_W);
      chk($sformatf("midreset_committed[%0d]", k), 72'(fc[k]), 72'd0);
      chk($sformatf("midreset_dropped[%0d]", k), 72'(fd[k]), 72'd0);
      chk($sformatf("midreset_level[%0d]", k), 72'(lvl[k]), 72'd0);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);
    send_frame(6, 5, 1'b0, 1'b1, 1'b1, first);
    idle(20);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("post_reset_committed[%0d]", k), 72'(fc[k]), 72'd1);
      chk($sformatf("post_reset_dropped[%0d]", k), 72'(fd[k]), 72'd0);
      chk($sformatf("post_reset_level[%0d]", k), 72'(lvl[k]), 72'd0);
      chk($sformatf("scoreboard_drained[%0d]", k), 72'(sbq[k].size()), 72'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
